// File: rtl/ctrl_sig_pipe.sv
// ctrl_sig_pipe: per-stage control-signal pipeline with stall, flush, bubble insertion and
// an invalid-instruction exception raised when an invalid entry reaches the last stage.
module ctrl_sig_pipe #(
   parameter int SIG_W  = 14,
   parameter int STAGES = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SIG_W-1:0]        signs_d,
   input  logic                    valid_d,
   input  logic                    invalid_d,
   input  logic                    stall_d,
   input  logic [STAGES-1:0]       stall,
   input  logic [STAGES-1:0]       flush,
   output logic [STAGES*SIG_W-1:0] signs_q,
   output logic [STAGES-1:0]       valid_q,
   output logic [STAGES-1:0]       inv_q,
   output logic                    exc_o,
   output logic [3:0]              inflight
);
   logic [STAGES*SIG_W-1:0] stg_s_q, stg_s_d;
   logic [STAGES-1:0] stg_v_q, stg_v_d, stg_i_q, stg_i_d, clr;
   // slot 0 is the decode stage, slot i+1 is pipeline stage i
   logic [(STAGES+1)*SIG_W-1:0] up_s;
   logic [STAGES:0] up_v, up_i, up_st;
   assign up_s  = {stg_s_q, signs_d};
   assign up_v  = {stg_v_q, valid_d};
   assign up_i  = {stg_i_q, invalid_d};
   assign up_st = {stall, stall_d};
   assign signs_q = up_s[(STAGES+1)*SIG_W-1:SIG_W];
   assign valid_q = up_v[STAGES:1];
   assign inv_q   = up_i[STAGES:1];
   assign exc_o   = up_v[STAGES] & up_i[STAGES];
   always_comb begin
      stg_s_d  = stg_s_q;
      stg_v_d  = stg_v_q;
      stg_i_d  = stg_i_q;
      clr      = '0;
      inflight = '0;
      for (int i = 0; i < STAGES; i++) begin
         clr[i] = exc_o | flush[i] | (~up_st[i+1] & up_st[i]);
         stg_s_d[i*SIG_W +: SIG_W] = clr[i] ? '0 : up_st[i+1] ? stg_s_q[i*SIG_W +: SIG_W] : up_s[i*SIG_W +: SIG_W];
         stg_v_d[i] = clr[i] ? 1'b0 : up_st[i+1] ? stg_v_q[i] : up_v[i];
         stg_i_d[i] = clr[i] ? 1'b0 : up_st[i+1] ? stg_i_q[i] : up_i[i];
         inflight   = inflight + {3'b000, stg_v_q[i]};
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_s_q <= '0;
         stg_v_q <= '0;
         stg_i_q <= '0;
      end else begin
         stg_s_q <= stg_s_d;
         stg_v_q <= stg_v_d;
         stg_i_q <= stg_i_d;
      end
   end
endmodule

// File: tb/tb_ctrl_sig_pipe.sv
// tb_ctrl_sig_pipe: checks a default (3-stage, 14-bit) and a 1-stage, 20-bit pipeline
// against a stage-array model, with directed scenarios and randomized traffic.
module tb_ctrl_sig_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [19:0] in_s [2];
   logic        in_v [2];
   logic        in_i [2];
   logic        in_sd [2];
   logic [7:0]  in_st [2];
   logic [7:0]  in_fl [2];

   logic [41:0] s0;
   logic [2:0]  v0, i0;
   logic        e0;
   logic [3:0]  n0;
   logic [19:0] s1;
   logic        v1, i1, e1;
   logic [3:0]  n1;

   int checks = 0;
   int errors = 0;

   logic [19:0] ms [2][8];
   logic        mv [2][8];
   logic        mi [2][8];

   ctrl_sig_pipe #(.SIG_W(14), .STAGES(3)) dut0 (
      .clk(clk), .rst(rst), .signs_d(in_s[0][13:0]), .valid_d(in_v[0]), .invalid_d(in_i[0]),
      .stall_d(in_sd[0]), .stall(in_st[0][2:0]), .flush(in_fl[0][2:0]),
      .signs_q(s0), .valid_q(v0), .inv_q(i0), .exc_o(e0), .inflight(n0)
   );

   ctrl_sig_pipe #(.SIG_W(20), .STAGES(1)) dut1 (
      .clk(clk), .rst(rst), .signs_d(in_s[1]), .valid_d(in_v[1]), .invalid_d(in_i[1]),
      .stall_d(in_sd[1]), .stall(in_st[1][0:0]), .flush(in_fl[1][0:0]),
      .signs_q(s1), .valid_q(v1), .inv_q(i1), .exc_o(e1), .inflight(n1)
   );

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, a, e, $time);
      end
   endtask

   task automatic mclr();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 8; i++) begin
            ms[k][i] = '0;
            mv[k][i] = 1'b0;
            mi[k][i] = 1'b0;
         end
   endtask

   task automatic mset(input int k, input int i, input logic [19:0] s, input logic v, input logic iv);
      ms[k][i] = s;
      mv[k][i] = v;
      mi[k][i] = iv;
   endtask

   // Walk from the last stage down so each stage still sees its upstream's old contents.
   task automatic step(input int k, input int n);
      logic e, uv, ui, ust;
      logic [19:0] us;
      e = mv[k][n-1] & mi[k][n-1];
      for (int i = n - 1; i >= 0; i--) begin
         if (i == 0) begin
            us = in_s[k]; uv = in_v[k]; ui = in_i[k]; ust = in_sd[k];
         end else begin
            us = ms[k][i-1]; uv = mv[k][i-1]; ui = mi[k][i-1]; ust = in_st[k][i-1];
         end
         if (e || in_fl[k][i]) mset(k, i, 0, 0, 0);
         else if (!in_st[k][i]) begin
            if (ust) mset(k, i, 0, 0, 0);
            else mset(k, i, us, uv, ui);
         end
      end
   endtask

   task automatic set(input int k, input logic [19:0] s, input logic v, input logic iv,
                      input logic [7:0] st, input logic [7:0] fl);
      in_s[k] = s; in_v[k] = v; in_i[k] = iv; in_sd[k] = 1'b0; in_st[k] = st; in_fl[k] = fl;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst) mclr();
      else begin
         step(0, 3);
         step(1, 1);
      end
      #2;
   endtask

   int pc;
   always @(negedge clk) begin
      pc = 0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("d0_sig%0d", i), {18'd0, s0[i*14 +: 14]}, {12'd0, ms[0][i]});
         chk($sformatf("d0_val%0d", i), {31'd0, v0[i]}, {31'd0, mv[0][i]});
         chk($sformatf("d0_inv%0d", i), {31'd0, i0[i]}, {31'd0, mi[0][i]});
         pc += int'(mv[0][i]);
      end
      chk("d0_exc", {31'd0, e0}, {31'd0, mv[0][2] & mi[0][2]});
      chk("d0_inflight", {28'd0, n0}, pc);
      chk("d1_sig", {12'd0, s1}, {12'd0, ms[1][0]});
      chk("d1_val", {31'd0, v1}, {31'd0, mv[1][0]});
      chk("d1_inv", {31'd0, i1}, {31'd0, mi[1][0]});
      chk("d1_exc", {31'd0, e1}, {31'd0, mv[1][0] & mi[1][0]});
      chk("d1_inflight", {28'd0, n1}, {31'd0, mv[1][0]});
   end

   initial begin
      set(0, 0, 0, 0, 0, 0);
      set(1, 0, 0, 0, 0, 0);
      mclr();
      #12;
      chk("rst_v0", v0, 0); chk("rst_s0", s0[31:0], 0); chk("rst_e0", e0, 0); chk("rst_n0", n0, 0);
      chk("rst_v1", v1, 0); chk("rst_e1", e1, 0); chk("rst_n1", n1, 0);
      rst = 1'b0;
      set(0, 'h60, 1, 0, 0, 0); set(1, 'h60, 1, 0, 0, 0);
      cyc();
      chk("flow_c1_sig", s0[13:0], 'h60); chk("flow_c1_val", v0, 3'b001); chk("flow_c1_n", n0, 1);
      chk("flow1_sig", s1, 'h60); chk("flow1_val", v1, 1); chk("flow1_n", n1, 1);
      set(0, 0, 0, 0, 0, 0); set(1, 'hABCDE, 1, 0, 0, 1);
      cyc();
      chk("flow_c2_sig", s0[27:14], 'h60); chk("flow_c2_val", v0, 3'b010); chk("flow_c2_n", n0, 1);
      chk("flush1_sig", s1, 0); chk("flush1_val", v1, 0);
      set(1, 0, 0, 0, 0, 0);
      cyc();
      chk("flow_c3_sig", s0[41:28], 'h60); chk("flow_c3_val", v0, 3'b100); chk("flow_c3_n", n0, 1);
      chk("flow_c3_exc", e0, 0);
      cyc();
      chk("flow_c4_val", v0, 0);
      set(0, 'h123, 1, 1, 0, 0); set(1, 'h777, 1, 1, 0, 0);
      cyc();
      chk("exc1_c1", e1, 1); chk("exc_c1", e0, 0);
      set(0, 'h200, 1, 0, 0, 0); set(1, 0, 0, 0, 0, 0);
      cyc();
      chk("exc1_c2", e1, 0); chk("exc1_c2_n", n1, 0); chk("exc_c2", e0, 0);
      set(0, 'h300, 1, 0, 0, 0);
      cyc();
      chk("exc_c3", e0, 1); chk("exc_c3_n", n0, 3); chk("exc_c3_inv", i0, 3'b100);
      set(0, 'h500, 1, 0, 0, 0);
      cyc();
      chk("exc_c4_sig", s0[31:0], 0); chk("exc_c4_val", v0, 0); chk("exc_c4_exc", e0, 0);
      chk("exc_c4_n", n0, 0);
      set(0, 'h0A1, 1, 0, 0, 0);
      cyc();
      chk("stall_load", s0[13:0], 'h0A1);
      set(0, 'h0B2, 1, 0, 1, 0);
      cyc();
      chk("stall_e1_hold", s0[13:0], 'h0A1); chk("stall_e1_bv", v0[1], 0); chk("stall_e1_bs", s0[27:14], 0);
      set(0, 'h0C3, 1, 0, 1, 0);
      cyc();
      chk("stall_e2_hold", s0[13:0], 'h0A1); chk("stall_e2_bv", v0[1], 0); chk("stall_e2_bs", s0[27:14], 0);
      set(0, 'h0D4, 1, 0, 0, 0);
      cyc();
      chk("stall_e3_s0", s0[13:0], 'h0D4); chk("stall_e3_s1", s0[27:14], 'h0A1); chk("stall_e3_v", v0, 3'b011);
      set(0, 'h0E5, 1, 0, 2, 2);
      cyc();
      chk("fos_val", v0, 3'b001); chk("fos_sig12", s0[41:14], 0); chk("fos_s0", s0[13:0], 'h0E5);
      set(0, 'h111, 1, 0, 0, 0); cyc();
      set(0, 'h222, 1, 0, 0, 0); cyc();
      set(0, 'h333, 1, 0, 0, 0); cyc();
      chk("pre_rst_n", n0, 3);
      rst = 1'b1;
      mclr();
      #1;
      chk("arst_sig", s0[31:0], 0); chk("arst_sigh", s0[41:32], 0); chk("arst_val", v0, 0);
      chk("arst_inv", i0, 0); chk("arst_exc", e0, 0); chk("arst_n", n0, 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      set(0, 'h444, 1, 0, 0, 0);
      cyc();
      chk("post_rst_s0", s0[13:0], 'h444); chk("post_rst_n", n0, 1);
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            in_s[k]  = 20'($urandom) & (k == 0 ? 20'h03fff : 20'hfffff);
            in_v[k]  = $urandom_range(0, 3) != 0;
            in_i[k]  = $urandom_range(0, 9) == 0;
            in_sd[k] = $urandom_range(0, 5) == 0;
            in_st[k] = 8'($urandom & $urandom & $urandom) & (k == 0 ? 8'h07 : 8'h01);
            in_fl[k] = 8'($urandom & $urandom & $urandom & $urandom) & (k == 0 ? 8'h07 : 8'h01);
         end
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            mclr();
            @(negedge clk);
            #1;
            rst = 1'b0;
         end
         cyc();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ctrl_sig_pipe.md
CTRL_SIG_PIPE -- requirements
Module: ctrl_sig_pipe

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter: SIG_W, default 14, width of one decoded control-signal vector.
REQ-003 Parameter: STAGES, default 3, range 1..8, number of pipeline stages after decode (stage 0 = E, 1 = M, 2 = W at default).
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: signs_d  input  SIG_W  control vector produced by the decode stage.
REQ-007 Port: valid_d  input  1  decode stage holds a real instruction.
REQ-008 Port: invalid_d  input  1  decode flagged a reserved or undefined instruction.
REQ-009 Port: stall_d  input  1  decode stage stalled this cycle.
REQ-010 Port: stall  input  STAGES  per-stage hold; bit i applies to stage i.
REQ-011 Port: flush  input  STAGES  per-stage clear; bit i applies to stage i.
REQ-012 Port: signs_q  output  STAGES*SIG_W  registered vectors; stage i occupies bits [i*SIG_W +: SIG_W].
REQ-013 Port: valid_q  output  STAGES  registered per-stage valid.
REQ-014 Port: inv_q  output  STAGES  registered per-stage invalid-instruction flag.
REQ-015 Port: exc_o  output  1  invalid instruction reached the last stage.
REQ-016 Port: inflight  output  4  number of valid stages.

Function
REQ-017 Each stage SHALL hold three registers: signs (SIG_W bits), valid and inv.
REQ-018 Upstream of stage 0 SHALL be {signs_d, valid_d, invalid_d}; upstream of stage i>0 SHALL be stage i-1.
REQ-019 Upstream stall SHALL be stall_d for stage 0 and stall[i-1] for stage i>0.
REQ-020 At each clock edge, stage i SHALL update by the following priority, highest first.
REQ-021 Priority 1: if exc_o was 1 during the cycle, the stage SHALL clear signs, valid and inv to 0.
REQ-022 Priority 2: if flush[i]=1, the stage SHALL clear signs, valid and inv to 0.
REQ-023 Priority 3: if stall[i]=1, the stage SHALL hold its current contents.
REQ-024 Priority 4: if upstream stall=1, the stage SHALL load a bubble (all zero) so an upstream entry is never duplicated.
REQ-025 Priority 5: otherwise, the stage SHALL load its upstream contents.
REQ-026 Latency: a non-stalled, non-flushed entry SHALL appear in stage i exactly i+1 cycles after it is presented at the decode stage.
REQ-027 exc_o SHALL be combinational and equal valid_q[STAGES-1] AND inv_q[STAGES-1].
REQ-028 An entry with valid=0 SHALL never assert exc_o, whatever its inv bit.
REQ-029 inflight SHALL be combinational and equal the population count of valid_q, zero-extended to 4 bits.
REQ-030 Simultaneous flush[i] and stall[i] SHALL resolve to flush.
REQ-031 Simultaneous stall[i]=1 and stall[i-1]=1 SHALL hold both stages, with no bubble inserted.
REQ-032 When stall[i]=1 and stall[i+1]=0, stage i+1 SHALL receive a bubble.
REQ-033 A flushed or bubbled stage SHALL present signs=0, so every write enable it carries is inactive.
REQ-034 With STAGES=1, stage 0 SHALL be the last stage, and exc_o SHALL derive from it.

Reset
REQ-035 While rst=1, every signs, valid and inv register SHALL be 0 immediately, regardless of clk.
REQ-036 While rst=1, exc_o SHALL be 0 and inflight SHALL be 0.
REQ-037 rst asserted mid-operation SHALL discard all in-flight entries.
REQ-038 After rst deasserts, the first edge SHALL load stage 0 normally.

Verification
REQ-039 Straight flow, default parameters, signs_d=14'h0060, valid_d=1, invalid_d=0 for one cycle, no stall or flush -> stages 0, 1 and 2 each hold 14'h0060 with valid=1 on cycles 1, 2 and 3 respectively; inflight=1 on each of those cycles.
REQ-040 Stall boundary, stall=3'b001 for 2 cycles with continuous decode -> stage 0 holds its entry; stage 1 receives bubbles (valid=0, signs=0) on both edges; stage 0 resumes on the third edge.
REQ-041 Flush over stall, stall[1]=1 and flush[1]=1 in the same cycle -> stage 1 is cleared on the next edge; stage 2 receives the bubble the stall rule requires.
REQ-042 Invalid commit, invalid_d=1 and valid_d=1 injected once with STAGES=3 -> exc_o=1 on cycle 3 only; all stages are 0 on cycle 4, and inflight=0.
REQ-043 Reset mid-flight, rst pulsed asynchronously between edges with inflight=3 -> all outputs are 0 before the next edge.
REQ-044 Parameter sweep, STAGES=1 and SIG_W=20 -> flow, flush and exc_o behave as in REQ-039 through REQ-042 with a latency of 1.
